// File: rtl/cla_sub_64_pipe.sv
// Pipelined two's-complement subtractor: diff = op1 + ~op2 + 1, one SLICE-bit
// carry-lookahead slice resolved per stage, valid/ready handshake at both ends.
module cla_sub_64_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / SLICE;
  localparam int unsigned LAST   = STAGES - 1;

  // Parallel-prefix (Kogge-Stone) carry lookahead over one slice; returns {cout, sum}.
  function automatic logic [SLICE:0] cla_slice(
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b,
    input logic             cin
  );
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] gg;
    logic [SLICE-1:0] pp;
    logic [SLICE-1:0] c;
    p  = a ^ b;
    gg = a & b;
    pp = p;
    for (int d = 1; d < int'(SLICE); d = d * 2) begin
      for (int i = int'(SLICE) - 1; i >= d; i--) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    c[0] = cin;
    for (int i = 1; i < int'(SLICE); i++) begin
      c[i] = gg[i-1] | (pp[i-1] & cin);
    end
    return {gg[SLICE-1] | (pp[SLICE-1] & cin), p ^ c};
  endfunction

  // Inter-stage registers for stages 1..STAGES-1; the last stage is the output register.
  logic [STAGES-2:0] r_vld;
  logic [STAGES-2:0] r_c;
  logic [WIDTH-1:0]  r_a [STAGES-1];
  logic [WIDTH-1:0]  r_b [STAGES-1];
  logic [WIDTH-1:0]  r_s [STAGES-1];

  logic              w_adv;
  logic              w_ovf;
  logic [STAGES-1:0] w_ci;
  logic [STAGES-1:0] w_co;
  logic [WIDTH-1:0]  w_ai [STAGES];
  logic [WIDTH-1:0]  w_bi [STAGES];
  logic [WIDTH-1:0]  w_si [STAGES];
  logic [WIDTH-1:0]  w_so [STAGES];
  logic [SLICE-1:0]  w_sl [STAGES];

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  // Stage operand sources: the input port feeds stage 1, each later stage its predecessor.
  always_comb begin
    w_ai[0] = op1;
    w_bi[0] = ~op2;
    w_ci[0] = 1'b1;
    w_si[0] = '0;
    for (int k = 1; k < int'(STAGES); k++) begin
      w_ai[k] = r_a[k-1];
      w_bi[k] = r_b[k-1];
      w_ci[k] = r_c[k-1];
      w_si[k] = r_s[k-1];
    end
  end

  // Each stage resolves its own slice and merges it into the finished low bits.
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      {w_co[k], w_sl[k]} = cla_slice(w_ai[k][k*SLICE +: SLICE], w_bi[k][k*SLICE +: SLICE],
                                     w_ci[k]);
      w_so[k] = w_si[k];
      w_so[k][k*SLICE +: SLICE] = w_sl[k];
    end
  end

  // Operand MSBs ride along unresolved, so the original op1/op2 signs are still visible here.
  assign w_ovf = (w_ai[LAST][WIDTH-1] ^ ~w_bi[LAST][WIDTH-1])
               & (w_so[LAST][WIDTH-1] ^ w_ai[LAST][WIDTH-1]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vld     <= '0;
      r_c       <= '0;
      for (int k = 0; k < int'(STAGES) - 1; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
    end else if (w_adv) begin
      r_vld[0] <= in_valid;
      for (int k = 1; k < int'(STAGES) - 1; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
      for (int k = 0; k < int'(STAGES) - 1; k++) begin
        r_a[k] <= w_ai[k];
        r_b[k] <= w_bi[k];
        r_s[k] <= w_so[k];
        r_c[k] <= w_co[k];
      end
      out_valid <= r_vld[STAGES-2];
      diff      <= w_so[LAST];
      borrow    <= ~w_co[LAST];
      ovf       <= w_ovf;
    end
  end

endmodule

// File: tb/tb_cla_sub_64_pipe.sv
// Self-checking bench for cla_sub_64_pipe: directed boundary vectors plus randomized
// traffic against an arithmetic reference model and an in-order expectation queue.
module tb_cla_sub_64_pipe;

  typedef struct packed {
    logic [63:0] d;
    logic        b;
    logic        o;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] op1;
  logic [63:0] op2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        borrow;
  logic        ovf;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];

  cla_sub_64_pipe dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // Reference: plain unsigned/signed arithmetic, independent of any slicing.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b);
    exp_t               e;
    logic signed [64:0] s;
    e.d = a - b;
    e.b = (a < b);
    s   = $signed({a[63], a}) - $signed({b[63], b});
    e.o = (s[64] != s[63]);
    return e;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic r);
    in_valid  = v;
    op1       = a;
    op2       = b;
    out_ready = r;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, rnd64(), rnd64(), 1'b1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || diff !== 64'd0 || borrow !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b diff=%h borrow=%b ovf=%b expected all 0",
               out_valid, diff, borrow, ovf);
    end
    reset = 1'b1;
    drive(1'b0, 64'd0, 64'd0, 1'b1);
    @(posedge clock); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b expected 1", in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_accept cycle %0d got out_valid=%b expected 0", c, out_valid);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_directed();
    logic [63:0] va [8];
    logic [63:0] vb [8];
    logic [63:0] vd [8];
    logic        vbr [8];
    logic        vov [8];
    int          lat;
    logic        tmo;
    va[0] = 64'hbbbb_cdcd_aaaa_1111; vb[0] = 64'hffff_ffff_ffff_dddd;
    vd[0] = 64'hbbbb_cdcd_aaaa_3334; vbr[0] = 1'b1; vov[0] = 1'b0;
    va[1] = 64'h0;                   vb[1] = 64'h1;
    vd[1] = 64'hffff_ffff_ffff_ffff; vbr[1] = 1'b1; vov[1] = 1'b0;
    va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h1;
    vd[2] = 64'h7fff_ffff_ffff_ffff; vbr[2] = 1'b0; vov[2] = 1'b1;
    va[3] = 64'h0001_0000_0000_0000; vb[3] = 64'h1;
    vd[3] = 64'h0000_ffff_ffff_ffff; vbr[3] = 1'b0; vov[3] = 1'b0;
    va[4] = 64'h1234_5678_9abc_def0; vb[4] = 64'h1234_5678_9abc_def0;
    vd[4] = 64'h0;                   vbr[4] = 1'b0; vov[4] = 1'b0;
    va[5] = 64'h0;                   vb[5] = 64'h0;
    vd[5] = 64'h0;                   vbr[5] = 1'b0; vov[5] = 1'b0;
    va[6] = 64'h7fff_ffff_ffff_ffff; vb[6] = 64'hffff_ffff_ffff_ffff;
    vd[6] = 64'h8000_0000_0000_0000; vbr[6] = 1'b1; vov[6] = 1'b1;
    va[7] = 64'hffff_ffff_ffff_ffff; vb[7] = 64'h0000_0000_0001_0000;
    vd[7] = 64'hffff_ffff_fffe_ffff; vbr[7] = 1'b0; vov[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, va[i], vb[i], 1'b1);
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL dir%0d_in_ready got %b expected 1", i, in_ready);
      end
      @(posedge clock); #1;
      drive(1'b0, 64'd0, 64'd0, 1'b1);
      lat = 1;
      tmo = 1'b0;
      while (1'b1) begin
        @(negedge clock);
        if (out_valid === 1'b1) break;
        if (lat >= 12) begin
          tmo = 1'b1;
          break;
        end
        @(posedge clock); #1;
        lat++;
      end
      checks++;
      if (tmo || lat != 4) begin
        failures++;
        $display("FAIL dir%0d_latency got %0d (timeout=%b) expected 4", i, lat, tmo);
      end
      checks++;
      if (diff !== vd[i] || borrow !== vbr[i] || ovf !== vov[i]) begin
        failures++;
        $display("FAIL dir%0d_value got diff=%h borrow=%b ovf=%b expected diff=%h borrow=%b ovf=%b",
                 i, diff, borrow, ovf, vd[i], vbr[i], vov[i]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    int   n     = 0;
    int   first = -1;
    int   last  = -1;
    exp_t e;
    q.delete();
    for (int c = 0; c < 20; c++) begin
      if (c < 8) drive(1'b1, rnd64(), rnd64(), 1'b1);
      else       drive(1'b0, 64'd0, 64'd0, 1'b1);
      @(negedge clock);
      if (in_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_in_ready cycle %0d got %b expected 1", c, in_ready);
        end
      end
      if (out_valid === 1'b1) begin
        n++;
        if (first < 0) first = c;
        last = c;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL b2b_spurious cycle %0d got diff=%h expected no result", c, diff);
        end else begin
          e = q.pop_front();
          if (diff !== e.d || borrow !== e.b || ovf !== e.o) begin
            failures++;
            $display("FAIL b2b_order cycle %0d got %h/%b/%b expected %h/%b/%b",
                     c, diff, borrow, ovf, e.d, e.b, e.o);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(op1, op2));
      @(posedge clock); #1;
    end
    checks++;
    if (n != 8 || first != 4 || last != 11) begin
      failures++;
      $display("FAIL b2b_stream got n=%0d first=%0d last=%0d expected 8/4/11", n, first, last);
    end
  endtask

  task automatic test_stall();
    int          retired  = 0;
    logic        have_held = 1'b0;
    logic [63:0] h_d = '0;
    logic        h_b = 1'b0;
    logic        h_o = 1'b0;
    exp_t        e;
    q.delete();
    for (int c = 0; c < 20; c++) begin
      drive(c < 3, rnd64(), rnd64(), c >= 6);
      @(negedge clock);
      if (have_held) begin
        checks++;
        if (out_valid !== 1'b1 || diff !== h_d || borrow !== h_b || ovf !== h_o) begin
          failures++;
          $display("FAIL stall_hold cycle %0d got %b %h/%b/%b expected 1 %h/%b/%b",
                   c, out_valid, diff, borrow, ovf, h_d, h_b, h_o);
        end
      end
      if (out_valid === 1'b1 && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_in_ready cycle %0d got %b expected 0", c, in_ready);
        end
      end
      have_held = (out_valid === 1'b1) && !out_ready;
      h_d = diff;
      h_b = borrow;
      h_o = ovf;
      if (out_valid === 1'b1 && out_ready) begin
        retired++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL stall_spurious cycle %0d got diff=%h expected no result", c, diff);
        end else begin
          e = q.pop_front();
          if (diff !== e.d || borrow !== e.b || ovf !== e.o) begin
            failures++;
            $display("FAIL stall_order cycle %0d got %h/%b/%b expected %h/%b/%b",
                     c, diff, borrow, ovf, e.d, e.b, e.o);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(op1, op2));
      @(posedge clock); #1;
    end
    checks++;
    if (retired != 3 || q.size() != 0) begin
      failures++;
      $display("FAIL stall_drain got retired=%0d pending=%0d expected 3/0", retired, q.size());
    end
  endtask

  task automatic test_random();
    logic        have_held = 1'b0;
    logic [63:0] h_d = '0;
    logic        h_b = 1'b0;
    logic        h_o = 1'b0;
    logic [63:0] a;
    logic [63:0] b;
    exp_t        e;
    q.delete();
    for (int c = 0; c < 340; c++) begin
      a = rnd64();
      case ($urandom_range(0, 3))
        0: b = rnd64();
        1: b = a;
        2: b = a + 64'($urandom_range(0, 3)) - 64'd1;
        default: begin
          a = {$urandom_range(0, 1) == 1, 63'd0};
          b = 64'($urandom_range(0, 2));
        end
      endcase
      if (c < 300) drive($urandom_range(0, 9) < 7, a, b, $urandom_range(0, 9) < 6);
      else         drive(1'b0, a, b, 1'b1);
      @(negedge clock);
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        failures++;
        $display("FAIL rnd_in_ready cycle %0d got %b expected %b", c, in_ready,
                 !out_valid || out_ready);
      end
      if (have_held) begin
        checks++;
        if (out_valid !== 1'b1 || diff !== h_d || borrow !== h_b || ovf !== h_o) begin
          failures++;
          $display("FAIL rnd_hold cycle %0d got %b %h expected 1 %h", c, out_valid, diff, h_d);
        end
      end
      have_held = (out_valid === 1'b1) && !out_ready;
      h_d = diff;
      h_b = borrow;
      h_o = ovf;
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rnd_spurious cycle %0d got diff=%h expected no result", c, diff);
        end else begin
          e = q.pop_front();
          if (diff !== e.d || borrow !== e.b || ovf !== e.o) begin
            failures++;
            $display("FAIL rnd_value cycle %0d got %h/%b/%b expected %h/%b/%b",
                     c, diff, borrow, ovf, e.d, e.b, e.o);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(op1, op2));
      @(posedge clock); #1;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL rnd_drain got pending=%0d expected 0", q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int   lat;
    logic tmo;
    exp_t e;
    for (int c = 0; c < 12; c++) begin
      drive(c < 2, rnd64(), rnd64(), 1'b0);
      @(negedge clock);
      if (out_valid === 1'b1) break;
      @(posedge clock); #1;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_fill got out_valid=%b expected 1", out_valid);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== 64'd0 || borrow !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL mid_async_clear got valid=%b diff=%h borrow=%b ovf=%b expected all 0",
               out_valid, diff, borrow, ovf);
    end
    #2 reset = 1'b1;
    drive(1'b0, 64'd0, 64'd0, 1'b1);
    @(posedge clock); #1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_stale cycle %0d got out_valid=%b expected 0", c, out_valid);
      end
      @(posedge clock); #1;
    end
    drive(1'b1, rnd64(), rnd64(), 1'b1);
    e = model(op1, op2);
    @(posedge clock); #1;
    drive(1'b0, 64'd0, 64'd0, 1'b1);
    lat = 1;
    tmo = 1'b0;
    while (1'b1) begin
      @(negedge clock);
      if (out_valid === 1'b1) break;
      if (lat >= 12) begin
        tmo = 1'b1;
        break;
      end
      @(posedge clock); #1;
      lat++;
    end
    checks++;
    if (tmo || lat != 4 || diff !== e.d || borrow !== e.b || ovf !== e.o) begin
      failures++;
      $display("FAIL mid_post_reset got lat=%0d %h/%b/%b expected lat=4 %h/%b/%b",
               lat, diff, borrow, ovf, e.d, e.b, e.o);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
